bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Shares one port of the team's inferable true dual-port block RAM among NREQ requesters. Each requester posts a burst command (read or write, start address, length), and the block grants bursts round-robin. It then drives the RAM port one beat per cycle and returns read data tagged with the requester ID. It sits between client engines and either RAM port (A or B), in the same clock domain as that port.

## Interface
- DATA, 72, RAM word width
- ADDR, 10, RAM address width; depth 2**ADDR
- NREQ, 4, number of requesters (2..8)
- LEN_W, 4, burst length field width; length = req_len+1 beats (1..2**LEN_W)
- ID_W, $clog2(NREQ), requester ID width
- clk  in  1  single clock, also clocks the RAM port
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  command pending per requester
- req_ready  out  NREQ  one-hot; command accepted this cycle
- req_wr  in  NREQ  1 = write burst, 0 = read burst
- req_addr  in  NREQ*ADDR  start address; requester i at [i*ADDR +: ADDR]
- req_len  in  NREQ*LEN_W  beats minus one
- wr_data  in  NREQ*DATA  write data per requester; sampled for requester i on every cycle gnt[i]=1 and the burst is a write
- gnt  out  NREQ  one-hot; beat issued for this requester this cycle
- mem_wr  out  1  to RAM port write enable
- mem_addr  out  ADDR  to RAM port address
- mem_din  out  DATA  to RAM port write data
- mem_dout  in  DATA  from RAM port read data (1-cycle latency)
- rd_valid  out  1  read beat returned
- rd_id  out  ID_W  owner of returned beat
- rd_data  out  DATA  returned word
- rd_last  out  1  final beat of the read burst

## Operation
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid is high, pick a winner, assert req_ready[winner] for one cycle, and latch id, wr, addr and len. Next state is BURST.
  - Otherwise stay in IDLE.
- BURST, every cycle:
  - Assert gnt[id] and drive mem_addr=cur_addr and mem_wr=wr.
  - Drive mem_din=wr_data[id] for write bursts and 0 for read bursts.
  - Step cur_addr by +1, wrapping modulo 2**ADDR (e.g. 0x3FF -> 0x000 at ADDR=10).
  - Decrement the beat counter.
- Last beat of a burst:
  - Arbitration runs in the same cycle. A winner is accepted (req_ready) on that cycle and its first beat issues on the next cycle, so there are no idle cycles between bursts.
  - With no winner, go to IDLE.
- Round-robin:
  - The search starts at ptr. After each acceptance, ptr = winner+1, modulo NREQ.
  - A requester whose command is refused stays pending; req_valid must be held until req_ready.
- Write bursts:
  - Requesters present wr_data combinationally for each gnt cycle. There is no write stall.
  - rd_valid is never raised for write beats, even though the RAM returns write-through data.
- Read bursts: the beat issued at cycle t returns on t+1 with rd_valid=1, rd_id=id and rd_data=mem_dout. rd_last=1 on the return of the final beat.
- Command fields are ignored while req_valid=0. Changing them while a command is pending but not yet accepted is legal; the values are latched on the cycle req_ready is high.

## Timing
- Reset (async assert) drives the following to 0: req_ready, gnt, mem_wr, mem_addr, mem_din, rd_valid, rd_id, rd_data, rd_last. ptr=0, state=IDLE.
- Reset mid-burst aborts the burst immediately, with no further beats. A pending read return is dropped.
- Latency: command accepted at cycle T, first beat at T+1, first read data at T+2. An N-beat read ends with rd_last at T+N+1.
- Throughput is one beat per cycle. Sustained back-to-back bursts lose zero cycles.
- req_ready and gnt are registered outputs of the FSM. They are never asserted for a requester whose req_valid is low.

## Configuration
- BRAM_ARB_PRIO0_EN defined: requester 0 wins whenever its req_valid is high at an arbitration point. Round-robin applies among requesters 1..NREQ-1 only, and ptr never points at 0.
- Not defined: pure round-robin over all NREQ requesters.

## Structure
- Package bram_arb_pkg holds:
  - state enum {IDLE, BURST}
  - default widths (DATA, ADDR, LEN_W)
  - a function computing ID_W from NREQ
- Sub-module rr_pick: combinational round-robin picker. Inputs are the request vector and ptr; outputs are the one-hot winner, a valid flag and the binary index. The BRAM_ARB_PRIO0_EN masking lives here.
- The top level holds the FSM, burst counter, address counter and read-return pipeline register.

## Test plan
- Single read: req 1, addr 0x010, len 3, RAM preloaded with 0x010->0xA0..0x013->0xA3. Required: req_ready[1] at T, gnt[1] over T+1..T+4, rd_data 0xA0..0xA3 over T+2..T+5 with rd_id=1, rd_last only at T+5.
- Write then read: req 2 writes 4 beats 0x55.. at 0x3FE. Required: writes land at 0x3FE, 0x3FF, 0x000, 0x001 (wrap). A readback returns the same values, and no rd_valid appears during the write.
- Contention: all 4 requesters hold 1-beat reads. Required: grant order 0,1,2,3,0; no idle cycles between bursts; each read returns with the correct rd_id.
- BRAM_ARB_PRIO0_EN defined, req0 and req2 valid continuously: req0 wins every arbitration; req2 gets no grant while req0 is requesting. Macro undefined: grants alternate 0,2,0,2.
- Reset mid-burst: assert rst during beat 2 of an 8-beat read. Required: all outputs go to 0 asynchronously and no further gnt occurs. After release, req 3 is accepted first from ptr=0 when it is the only requester.
- Held request: req 1 asserted while req 0 is bursting 16 beats. Required: req_ready[1] on req 0's last-beat cycle, and req 1's first beat on the next cycle.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types, default widths and helpers for the block-RAM port arbiter.
package bram_arb_pkg;

    localparam int unsigned DEF_DATA  = 72;
    localparam int unsigned DEF_ADDR  = 10;
    localparam int unsigned DEF_LEN_W = 4;
    localparam int unsigned DEF_NREQ  = 4;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    function automatic int unsigned id_width(input int unsigned nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// Combinational round-robin picker; BRAM_ARB_PRIO0_EN gives requester 0 absolute priority.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    logic [NREQ-1:0] masked;
    int unsigned     cand;
    logic [ID_W-1:0] ci;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        masked = req;
        cand   = 0;
        ci     = '0;
`ifdef BRAM_ARB_PRIO0_EN
        if (req[0]) begin
            winner[0] = 1'b1;
            valid     = 1'b1;
        end
        masked[0] = 1'b0;
`endif
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            ci   = ID_W'(cand);
            if (!valid && masked[ci]) begin
                valid      = 1'b1;
                winner[ci] = 1'b1;
                idx        = ci;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin burst arbiter for one block-RAM port with tagged read return.
// Optional BRAM_ARB_PRIO0_EN: requester 0 always wins arbitration.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned DATA  = DEF_DATA,
    parameter int unsigned ADDR  = DEF_ADDR,
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned LEN_W = DEF_LEN_W,
    parameter int unsigned ID_W  = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_wr,
    input  logic [NREQ*ADDR-1:0]  req_addr,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ*DATA-1:0]  wr_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  mem_wr,
    output logic [ADDR-1:0]       mem_addr,
    output logic [DATA-1:0]       mem_din,
    input  logic [DATA-1:0]       mem_dout,
    output logic                  rd_valid,
    output logic [ID_W-1:0]       rd_id,
    output logic [DATA-1:0]       rd_data,
    output logic                  rd_last
);

    state_t          state, state_d;
    logic [ID_W-1:0] ptr, ptr_d, id, id_d, win_id, win_id_d;
    logic            wr, wr_d;
    logic [ADDR-1:0] cur_addr, cur_addr_d, mem_addr_d;
    logic [LEN_W-1:0] cnt, cnt_d;
    logic [NREQ-1:0] req_ready_d, gnt_d;
    logic            mem_wr_d;
    logic            accepting, last_beat, arb_en;
    logic [NREQ-1:0] pick_req, pick_win;
    logic            pick_valid;
    logic [ID_W-1:0] pick_idx;

    rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
        .req    (pick_req),
        .ptr    (ptr),
        .winner (pick_win),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // req_ready is registered, so arbitration runs one cycle ahead of the
    // cycle that can accept: the command just accepted is hidden from it.
    always_comb begin
        accepting   = |req_ready;
        last_beat   = (state == BURST) && (cnt == '0);
        state_d     = state;
        id_d        = id;
        wr_d        = wr;
        cur_addr_d  = cur_addr;
        cnt_d       = cnt;
        gnt_d       = '0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr;
        if (accepting) begin
            state_d    = BURST;
            id_d       = win_id;
            wr_d       = req_wr[win_id];
            mem_wr_d   = req_wr[win_id];
            mem_addr_d = req_addr[win_id*ADDR +: ADDR];
            cur_addr_d = req_addr[win_id*ADDR +: ADDR] + 1'b1;
            cnt_d      = req_len[win_id*LEN_W +: LEN_W];
            gnt_d      = NREQ'(1) << win_id;
        end else if ((state == BURST) && !last_beat) begin
            gnt_d      = gnt;
            mem_wr_d   = wr;
            mem_addr_d = cur_addr;
            cur_addr_d = cur_addr + 1'b1;
            cnt_d      = cnt - 1'b1;
        end else begin
            state_d = IDLE;
        end

        arb_en      = (state_d == IDLE) || (cnt_d == '0);
        pick_req    = req_valid & ~req_ready;
        req_ready_d = '0;
        win_id_d    = win_id;
        ptr_d       = ptr;
        if (arb_en && pick_valid) begin
            req_ready_d = pick_win;
            win_id_d    = pick_idx;
`ifdef BRAM_ARB_PRIO0_EN
            if (pick_idx != '0)
                ptr_d = (pick_idx == ID_W'(NREQ-1)) ? ID_W'(1) : pick_idx + 1'b1;
`else
            ptr_d = (pick_idx == ID_W'(NREQ-1)) ? '0 : pick_idx + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id        <= '0;
            win_id    <= '0;
            wr        <= 1'b0;
            cur_addr  <= '0;
            cnt       <= '0;
            req_ready <= '0;
            gnt       <= '0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            rd_valid  <= 1'b0;
            rd_id     <= '0;
            rd_last   <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            id        <= id_d;
            win_id    <= win_id_d;
            wr        <= wr_d;
            cur_addr  <= cur_addr_d;
            cnt       <= cnt_d;
            req_ready <= req_ready_d;
            gnt       <= gnt_d;
            mem_wr    <= mem_wr_d;
            mem_addr  <= mem_addr_d;
            rd_valid  <= (state == BURST) && !wr;
            rd_id     <= id;
            rd_last   <= last_beat;
        end
    end

    always_comb begin
        mem_din = ((state == BURST) && wr) ? wr_data[id*DATA +: DATA] : '0;
        rd_data = rd_valid ? mem_dout : '0;
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed scoreboard bench for bram_port_arbiter with a behavioural RAM model.
module tb_bram_port_arbiter;
    import bram_arb_pkg::*;

    localparam int unsigned DATA  = DEF_DATA;
    localparam int unsigned ADDR  = DEF_ADDR;
    localparam int unsigned NREQ  = DEF_NREQ;
    localparam int unsigned LEN_W = DEF_LEN_W;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned HLEN  = 1024;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_wr = '0;
    logic [NREQ*ADDR-1:0]  req_addr = '0;
    logic [NREQ*LEN_W-1:0] req_len = '0;
    logic [NREQ*DATA-1:0]  wr_data = '0;
    logic [NREQ-1:0]       gnt;
    logic                  mem_wr;
    logic [ADDR-1:0]       mem_addr;
    logic [DATA-1:0]       mem_din;
    logic [DATA-1:0]       mem_dout;
    logic                  rd_valid;
    logic [ID_W-1:0]       rd_id;
    logic [DATA-1:0]       rd_data;
    logic                  rd_last;

    bram_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data), .gnt(gnt), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .rd_valid(rd_valid),
        .rd_id(rd_id), .rd_data(rd_data), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    logic [DATA-1:0] ram [0:(1<<ADDR)-1];

    function automatic logic [DATA-1:0] initw(input int unsigned a);
        if (a >= 16 && a <= 19) return DATA'(32'hA0 + a - 16);
        return DATA'(32'hC000 + a);
    endfunction

    initial for (int unsigned a = 0; a < (1 << ADDR); a++) ram[a] = initw(a);

    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_din;
        mem_dout <= mem_wr ? mem_din : ram[mem_addr];
    end

    typedef struct {
        logic            wr;
        logic [ADDR-1:0] addr;
        logic [LEN_W-1:0] len;
    } cmd_t;
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [DATA-1:0] data;
        logic            last;
    } rd_t;

    cmd_t            cq [NREQ][$];
    logic [DATA-1:0] wq [NREQ][$];
    rd_t             exp_q[$];

    logic [NREQ-1:0] gnt_h [0:HLEN-1];
    logic [NREQ-1:0] rdy_h [0:HLEN-1];
    logic            rdv_h [0:HLEN-1];
    logic            rdl_h [0:HLEN-1];
    logic [ADDR-1:0] ma_h  [0:HLEN-1];
    logic [NREQ-1:0] rdy_s, gnt_s;
    logic            mw_s;
    int unsigned     cyc = 0;
    int unsigned     total = 0;
    int unsigned     bad = 0;

    task automatic chk(input string tag, input logic [DATA-1:0] obs, input logic [DATA-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_valid[i] = (cq[i].size() != 0);
            if (cq[i].size() != 0) begin
                req_wr[i]                  = cq[i][0].wr;
                req_addr[i*ADDR +: ADDR]   = cq[i][0].addr;
                req_len[i*LEN_W +: LEN_W]  = cq[i][0].len;
            end
            wr_data[i*DATA +: DATA] = (wq[i].size() != 0) ? wq[i][0] : '0;
        end
    endtask

    task automatic tick_drive();
        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (rdy_s[i] && cq[i].size() != 0) void'(cq[i].pop_front());
            if (gnt_s[i] && mw_s && wq[i].size() != 0) void'(wq[i].pop_front());
        end
        drive();
    endtask

    task automatic tick_sample();
        rd_t e;
        @(negedge clk);
        if (cyc < HLEN) begin
            gnt_h[cyc] = gnt;
            rdy_h[cyc] = req_ready;
            rdv_h[cyc] = rd_valid;
            rdl_h[cyc] = rd_last;
            ma_h[cyc]  = mem_addr;
        end
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_spurious", DATA'(rd_valid), '0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_id", DATA'(rd_id), DATA'(e.id));
                chk("rd_data", rd_data, e.data);
                chk("rd_last", DATA'(rd_last), DATA'(e.last));
            end
        end
        rdy_s = req_ready;
        gnt_s = gnt;
        mw_s  = mem_wr;
        cyc++;
    endtask

    task automatic step();
        tick_drive();
        tick_sample();
    endtask

    task automatic post(input int unsigned i, input logic w, input logic [ADDR-1:0] a, input logic [LEN_W-1:0] l);
        cmd_t c;
        c.wr = w; c.addr = a; c.len = l;
        cq[i].push_back(c);
        drive();
    endtask

    task automatic expect_read(input int unsigned i, input logic [ADDR-1:0] a, input int unsigned beats);
        rd_t e;
        logic [ADDR-1:0] aa;
        aa = a;
        for (int unsigned k = 0; k < beats; k++) begin
            e.id = ID_W'(i); e.data = ram[aa]; e.last = (k == beats - 1);
            exp_q.push_back(e);
            aa = aa + 1'b1;
        end
    endtask

    function automatic bit busy();
        bit b = (exp_q.size() != 0);
        for (int unsigned i = 0; i < NREQ; i++) b |= (cq[i].size() != 0) || (wq[i].size() != 0);
        return b;
    endfunction

    task automatic wait_done(input int unsigned budget);
        int unsigned n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        chk("wait_budget", DATA'(n < budget), DATA'(1));
        repeat (3) step();
    endtask

    initial begin
        int unsigned c0, cnt_v;
        int unsigned ord[6];
        logic [ADDR-1:0] adr[6];
        logic [NREQ-1:0] oh;
        rdy_s = '0; gnt_s = '0; mw_s = 1'b0;

        repeat (3) step();
        chk("rst_req_ready", DATA'(req_ready), '0);
        chk("rst_gnt", DATA'(gnt), '0);
        chk("rst_mem_wr", DATA'(mem_wr), '0);
        chk("rst_mem_addr", DATA'(mem_addr), '0);
        chk("rst_mem_din", mem_din, '0);
        chk("rst_rd_valid", DATA'(rd_valid), '0);
        chk("rst_rd_id", DATA'(rd_id), '0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_rd_last", DATA'(rd_last), '0);
        tick_drive(); rst = 1'b0; tick_sample();

        // single read, latency and tagging
        c0 = cyc - 1;
        expect_read(1, 10'h010, 4);
        post(1, 1'b0, 10'h010, 4'd3);
        wait_done(40);
        chk("t1_ready", DATA'(rdy_h[c0+1]), DATA'(4'b0010));
        chk("t1_addr0", DATA'(ma_h[c0+2]), DATA'(10'h010));
        for (int unsigned k = 0; k < 4; k++) begin
            chk("t1_gnt", DATA'(gnt_h[c0+2+k]), DATA'(4'b0010));
            chk("t1_rdv", DATA'(rdv_h[c0+3+k]), DATA'(1));
            chk("t1_last", DATA'(rdl_h[c0+3+k]), DATA'(k == 3));
        end
        chk("t1_gnt_end", DATA'(gnt_h[c0+6]), '0);

        // write burst across the address wrap, then readback
        c0 = cyc - 1;
        for (int unsigned k = 0; k < 4; k++) wq[2].push_back(DATA'(8'h55 + k));
        post(2, 1'b1, 10'h3FE, 4'd3);
        wait_done(40);
        cnt_v = 0;
        for (int unsigned k = 0; k < 10; k++) cnt_v += int'(rdv_h[c0+k]);
        chk("t2_no_rdv", DATA'(cnt_v), '0);
        chk("t2_ram3fe", ram[10'h3FE], DATA'(8'h55));
        chk("t2_ram3ff", ram[10'h3FF], DATA'(8'h56));
        chk("t2_ram000", ram[10'h000], DATA'(8'h57));
        chk("t2_ram001", ram[10'h001], DATA'(8'h58));
        for (int unsigned k = 0; k < 4; k++)
            exp_q.push_back('{id: ID_W'(2), data: DATA'(8'h55 + k), last: (k == 3)});
        post(2, 1'b0, 10'h3FE, 4'd3);
        wait_done(40);

        // reset during beat 2 of an 8-beat read
        c0 = cyc - 1;
        post(0, 1'b0, 10'h100, 4'd7);
        step(); step();
        tick_drive(); rst = 1'b1; #1;
        chk("ar_gnt", DATA'(gnt), '0);
        chk("ar_req_ready", DATA'(req_ready), '0);
        chk("ar_mem_wr", DATA'(mem_wr), '0);
        chk("ar_mem_addr", DATA'(mem_addr), '0);
        chk("ar_mem_din", mem_din, '0);
        chk("ar_rd_valid", DATA'(rd_valid), '0);
        chk("ar_rd_id", DATA'(rd_id), '0);
        chk("ar_rd_data", rd_data, '0);
        chk("ar_rd_last", DATA'(rd_last), '0);
        tick_sample();
        step(); step();
        tick_drive(); rst = 1'b0; tick_sample();
        repeat (6) step();
        oh = '0;
        for (int unsigned k = c0 + 3; k < cyc; k++) oh |= gnt_h[k];
        chk("ar_no_gnt", DATA'(oh), '0);
        c0 = cyc - 1;
        expect_read(3, 10'h030, 1);
        post(3, 1'b0, 10'h030, 4'd0);
        wait_done(20);
        chk("ar_req3_ready", DATA'(rdy_h[c0+1]), DATA'(4'b1000));

        // four-way contention with 1-beat reads
`ifdef BRAM_ARB_PRIO0_EN
        ord = '{0, 1, 0, 2, 3, 0};
        adr = '{10'h020, 10'h021, 10'h024, 10'h022, 10'h023, 10'h000};
`else
        ord = '{0, 1, 2, 3, 0, 0};
        adr = '{10'h020, 10'h021, 10'h022, 10'h023, 10'h024, 10'h000};
`endif
        c0 = cyc - 1;
        for (int unsigned k = 0; k < 5; k++) expect_read(ord[k], adr[k], 1);
        post(0, 1'b0, 10'h020, 4'd0);
        post(1, 1'b0, 10'h021, 4'd0);
        post(2, 1'b0, 10'h022, 4'd0);
        post(3, 1'b0, 10'h023, 4'd0);
        post(0, 1'b0, 10'h024, 4'd0);
        wait_done(40);
        chk("t4_ready0", DATA'(rdy_h[c0+1]), DATA'(4'b0001));
        for (int unsigned k = 0; k < 5; k++) begin
            oh = NREQ'(1) << ord[k];
            chk("t4_gnt_order", DATA'(gnt_h[c0+2+k]), DATA'(oh));
        end
        chk("t4_gnt_end", DATA'(gnt_h[c0+7]), '0);

        // request held while a 16-beat burst runs
        c0 = cyc - 1;
        expect_read(0, 10'h200, 16);
        expect_read(1, 10'h210, 1);
        post(0, 1'b0, 10'h200, 4'd15);
        repeat (3) step();
        post(1, 1'b0, 10'h210, 4'd0);
        wait_done(60);
        chk("t5_ready0", DATA'(rdy_h[c0+1]), DATA'(4'b0001));
        chk("t5_ready1", DATA'(rdy_h[c0+17]), DATA'(4'b0010));
        chk("t5_last0", DATA'(gnt_h[c0+17]), DATA'(4'b0001));
        chk("t5_first1", DATA'(gnt_h[c0+18]), DATA'(4'b0010));

        // park the pointer, then requesters 0 and 2 compete continuously
        expect_read(3, 10'h031, 1);
        post(3, 1'b0, 10'h031, 4'd0);
        wait_done(20);
`ifdef BRAM_ARB_PRIO0_EN
        ord = '{0, 0, 0, 2, 2, 2};
        adr = '{10'h300, 10'h302, 10'h304, 10'h310, 10'h312, 10'h314};
`else
        ord = '{0, 2, 0, 2, 0, 2};
        adr = '{10'h300, 10'h310, 10'h302, 10'h312, 10'h304, 10'h314};
`endif
        c0 = cyc - 1;
        for (int unsigned k = 0; k < 6; k++) expect_read(ord[k], adr[k], 2);
        for (int unsigned k = 0; k < 3; k++) begin
            post(0, 1'b0, ADDR'(10'h300 + 2*k), 4'd1);
            post(2, 1'b0, ADDR'(10'h310 + 2*k), 4'd1);
        end
        wait_done(60);
        for (int unsigned k = 0; k < 6; k++) begin
            oh = NREQ'(1) << ord[k];
            chk("t6_gnt_a", DATA'(gnt_h[c0+2+2*k]), DATA'(oh));
            chk("t6_gnt_b", DATA'(gnt_h[c0+3+2*k]), DATA'(oh));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
